// File: rtl/nn_pkg.sv
// Constants and FSM state encoding shared by the weight fetch unit and the master engine.
package nn_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 10;
  localparam int LEN_W  = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/weight_fetch_unit_if.sv
// Memory read port plus the valid/ready operand stream, seen from the fetch unit (master)
// and from the memory/engine side (slave).
interface weight_fetch_unit_if;

  logic                        mem_rd_en;
  logic [nn_pkg::ADDR_W-1:0]   mem_addr;
  logic [nn_pkg::DATA_W-1:0]   mem_rd_data;
  logic                        out_valid;
  logic                        out_ready;
  logic [nn_pkg::DATA_W-1:0]   out_data;
  logic                        out_last;

  modport master (
    output mem_rd_en, mem_addr, out_valid, out_data, out_last,
    input  mem_rd_data, out_ready
  );

  modport slave (
    input  mem_rd_en, mem_addr, out_valid, out_data, out_last,
    output mem_rd_data, out_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with occupancy count; push and pop may occur in the same cycle.
module fetch_fifo #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; an empty FIFO never exposes it because the reader gates the head.
  always_ff @(posedge clk) begin
    if (push) storage[wr_ptr] <= push_data;
  end

  assign head = storage[rd_ptr];

endmodule

// File: rtl/weight_fetch_unit.sv
// Streams a contiguous block of words from main memory into the engine, with a credit-limited
// read issue so that the local FIFO can never overflow under downstream backpressure.
module weight_fetch_unit
  import nn_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [ADDR_W-1:0]          base_addr,
  input  logic [LEN_W-1:0]           length,
  output logic                       busy,
  output logic                       done,
  weight_fetch_unit_if.master        bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  fetch_state_t      state, state_next;
  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W:0]    len_ext;
  logic [LEN_W:0]    issued;
  logic [LEN_W:0]    popped;
  logic              inflight;
  logic              rd_en;
  logic              pop;
  logic              accept;
  logic              fifo_valid;
  logic [CNT_W-1:0]  fifo_count;
  logic [DATA_W-1:0] fifo_head;

  assign len_ext = {1'b0, len_q};
  assign accept  = (state == IDLE) && start;

  // A read is only issued if the word it returns, plus the one already in flight, still fits.
  assign rd_en = (state == FETCH) && (issued < len_ext) &&
                 ((fifo_count + CNT_W'(inflight)) < CNT_W'(FIFO_DEPTH));

  assign fifo_valid = (fifo_count != '0);
  assign pop        = fifo_valid && bus.out_ready;

  fetch_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (bus.mem_rd_data),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  assign bus.mem_rd_en = rd_en;
  assign bus.mem_addr  = base_q + ADDR_W'(issued);
  assign bus.out_valid = fifo_valid;
  assign bus.out_data  = fifo_valid ? fifo_head : '0;
  assign bus.out_last  = fifo_valid && (popped == len_ext - (LEN_W + 1)'(1));
  assign busy          = (state == FETCH) || (state == DRAIN);
  assign done          = (state == DONE);

  // NOTE: defaults first so every path assigns state_next and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (length != '0) ? FETCH : DONE;
      FETCH:   if (issued == len_ext) state_next = DRAIN;
      DRAIN:   if (pop && (popped + (LEN_W + 1)'(1) == len_ext)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      base_q   <= '0;
      len_q    <= '0;
      issued   <= '0;
      popped   <= '0;
      inflight <= 1'b0;
    end else begin
      state    <= state_next;
      inflight <= rd_en;
      if (accept) begin
        base_q <= base_addr;
        len_q  <= length;
        issued <= '0;
        popped <= '0;
      end else begin
        if (rd_en) issued <= issued + 1'b1;
        if (pop)   popped <= popped + 1'b1;
      end
    end
  end

endmodule
